memory_request_arbiter: RTL and testbench

//  Shares the simulation-only latency-simulated memory between NUM_REQ requesters
//  (e.g. 0 = ICache refill, 1 = DCache miss/writeback). Round-robin arbitration.

---
 rtl/memory_request_arbiter_pkg.sv | 13 +
 rtl/memory_request_arbiter_owner_fifo.sv | 43 ++++
 rtl/memory_request_arbiter.sv | 111 +++++++++++
 tb/tb_memory_request_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_request_arbiter_pkg.sv
// Shared types and sizes for the round-robin, credit-limited front end of the
// latency-simulated memory.
package memory_request_arbiter_pkg;

    localparam int MEM_ARB_REQ_NUM            = 2;
    localparam int MEM_LATENCY_SIM_QUEUE_SIZE = 8;
    localparam int MEM_REQ_PATH_W             = 32;

    typedef logic [MEM_REQ_PATH_W-1:0]                  mem_req_path_t;
    typedef logic [$clog2(MEM_ARB_REQ_NUM)-1:0]         mem_arb_req_idx_t;
    typedef logic [$clog2(MEM_LATENCY_SIM_QUEUE_SIZE):0] mem_arb_count_t;

endpackage

// File: rtl/memory_request_arbiter_owner_fifo.sv
// Owner FIFO: remembers which requester made each request pushed into the
// simulator so every issue can be tagged with its owner.
module mem_arb_owner_fifo #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [IDX_W-1:0] push_idx_i,
    output logic [IDX_W-1:0] head_idx_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
    logic [IDX_W-1:0] entries_q [DEPTH];

    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head_idx_o = entries_q[rd_ptr_q[PTR_W-1:0]];

    // When full, a same-cycle push/pop writes the slot whose head is read out now.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            entries_q <= '{default: '0};
        end else begin
            if (push_i) begin
                entries_q[wr_ptr_q[PTR_W-1:0]] <= push_idx_i;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_request_arbiter.sv
// Round-robin arbiter with credit control in front of the latency-simulated
// memory; tags each simulator issue with the requester that pushed it.
module memory_request_arbiter
    import memory_request_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = MEM_ARB_REQ_NUM,
    parameter int QUEUE_SIZE = MEM_LATENCY_SIM_QUEUE_SIZE
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic          [NUM_REQ-1:0]     req_valid_i,
    input  mem_req_path_t [NUM_REQ-1:0]     req_data_i,
    output logic          [NUM_REQ-1:0]     req_grant_o,
    output logic                            sim_push_o,
    output mem_req_path_t                   sim_pushed_data_o,
    input  logic                            sim_has_request_i,
    output logic                            issue_valid_o,
    output logic [$clog2(NUM_REQ)-1:0]      issue_owner_o,
    output logic [$clog2(QUEUE_SIZE):0]     outstanding_o
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(QUEUE_SIZE) + 1;

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] pick_idx, cand;
    logic [IDX_W:0]   scan_sum;
    logic             pick_found, can_push;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic             fifo_empty, fifo_full;

    // A pop in this cycle frees its slot for a push in the same cycle.
    assign can_push = (outstanding_q < CNT_W'(QUEUE_SIZE)) || sim_has_request_i;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_sum   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (scan_sum >= (IDX_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = scan_sum[IDX_W-1:0];
            if (!pick_found && req_valid_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        req_grant_o       = '0;
        sim_push_o        = 1'b0;
        sim_pushed_data_o = '0;
        if (can_push && pick_found) begin
            req_grant_o[pick_idx] = 1'b1;
            sim_push_o            = 1'b1;
            sim_pushed_data_o     = req_data_i[pick_idx];
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (sim_push_o) begin
            rr_ptr_d = (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + IDX_W'(1);
        end
        unique case ({sim_push_o, sim_has_request_i})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
        end
    end

    mem_arb_owner_fifo #(
        .DEPTH (QUEUE_SIZE),
        .IDX_W (IDX_W)
    ) u_owner_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (sim_push_o),
        .pop_i      (sim_has_request_i),
        .push_idx_i (pick_idx),
        .head_idx_o (issue_owner_o),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    assign issue_valid_o = sim_has_request_i;
    assign outstanding_o = outstanding_q;

    a_no_pop_when_idle: assert property (@(posedge clk) disable iff (rst)
        sim_has_request_i |-> (outstanding_q != '0) && !fifo_empty);
    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        outstanding_q <= CNT_W'(QUEUE_SIZE));
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_grant_o));
    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (sim_push_o && !sim_has_request_i) |-> !fifo_full);

endmodule

// File: tb/tb_memory_request_arbiter.sv
// Self-checking bench: reference model plus owner scoreboard, a fairness vector
// table and hand-written sequences for credit, ordering, reset and hold cases.
module tb_memory_request_arbiter;
    import memory_request_arbiter_pkg::*;

    localparam int NR = MEM_ARB_REQ_NUM;
    localparam int QS = MEM_LATENCY_SIM_QUEUE_SIZE;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic          [NR-1:0]     req_valid = '0;
    mem_req_path_t [NR-1:0]     req_data;
    logic          [NR-1:0]     req_grant;
    logic                       sim_push;
    mem_req_path_t              sim_pushed_data;
    logic                       sim_has_request = 1'b0;
    logic                       issue_valid;
    logic [$clog2(NR)-1:0]      issue_owner;
    logic [$clog2(QS):0]        outstanding;

    memory_request_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid_i       (req_valid),
        .req_data_i        (req_data),
        .req_grant_o       (req_grant),
        .sim_push_o        (sim_push),
        .sim_pushed_data_o (sim_pushed_data),
        .sim_has_request_i (sim_has_request),
        .issue_valid_o     (issue_valid),
        .issue_owner_o     (issue_owner),
        .outstanding_o     (outstanding)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int m_rr, m_out, cyc;
    int owner_q[$];
    int ts_q[$];
    bit last_push;
    int last_idx;

    typedef struct {
        logic [NR-1:0] v;
        logic          hr;
        logic [NR-1:0] g;
        int            out;
        int            own;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        m_rr = 0; m_out = 0; last_push = 0; last_idx = 0;
        owner_q.delete();
        ts_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; sim_has_request = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    // One cycle: drive at negedge, compare combinational outputs 1 time unit later.
    task automatic step(input logic [NR-1:0] v, input logic hr,
                        output logic [NR-1:0] g, output int o, output int ow,
                        output mem_req_path_t pd);
        logic [NR-1:0] exp_g;
        bit can, found, push;
        int idx, j;
        @(negedge clk);
        if (last_push) req_data[last_idx] = $urandom;
        req_valid = v; sim_has_request = hr;
        #1;
        can = (m_out < QS) || hr;
        found = 0; idx = 0;
        for (int k = 0; k < NR; k++) begin
            j = (m_rr + k) % NR;
            if (!found && v[j]) begin found = 1; idx = j; end
        end
        push  = can && found;
        exp_g = '0;
        if (push) exp_g[idx] = 1'b1;
        chk("grant", req_grant, exp_g);
        chk("push", sim_push, push);
        chk("pushed_data", sim_pushed_data, push ? req_data[idx] : '0);
        chk("issue_valid", issue_valid, hr);
        chk("outstanding", outstanding, m_out);
        g = req_grant; o = int'(outstanding); ow = int'(issue_owner); pd = sim_pushed_data;
        if (hr) begin
            if (owner_q.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_underflow: got issue with owner %0d, expected no issue", issue_owner);
            end else begin
                chk("issue_owner", issue_owner, owner_q.pop_front());
                void'(ts_q.pop_front());
            end
        end
        if (push) begin
            owner_q.push_back(idx);
            ts_q.push_back(cyc);
            m_rr = (idx + 1) % NR;
        end
        m_out = m_out + int'(push) - int'(hr);
        last_push = push; last_idx = idx;
        cyc++;
    endtask

    task automatic run_lat(input logic [NR-1:0] v, input int n);
        logic [NR-1:0] g; int o, ow; mem_req_path_t pd; logic hr;
        for (int i = 0; i < n; i++) begin
            hr = (ts_q.size() > 0) && (cyc >= ts_q[0] + 3);
            step(v, hr, g, o, ow, pd);
        end
    endtask

    initial begin
        logic [NR-1:0] g; int o, ow, ngr; mem_req_path_t pd, hold;
        int exp_own[4];
        cyc = 0;
        clear_model();
        for (int i = 0; i < NR; i++) req_data[i] = $urandom;

        // reset state
        do_reset();
        #1;
        chk("rst_grant", req_grant, '0);
        chk("rst_push", sim_push, 1'b0);
        chk("rst_issue_valid", issue_valid, 1'b0);
        chk("rst_issue_owner", issue_owner, '0);
        chk("rst_outstanding", outstanding, '0);

        // 1: single requester fills credits, stalls, then resumes after issues
        ngr = 0;
        for (int i = 0; i < QS + 2; i++) begin
            step(2'b01, 1'b0, g, o, ow, pd);
            if (g != '0) ngr++;
        end
        chk("fill_grants", ngr, QS);
        chk("stall_grant", g, '0);
        run_lat(2'b01, 12);

        // 2: fairness table
        do_reset();
        tbl[0] = '{v: 2'b11, hr: 1'b0, g: 2'b01, out: 0, own: 0};
        tbl[1] = '{v: 2'b11, hr: 1'b1, g: 2'b10, out: 1, own: 0};
        tbl[2] = '{v: 2'b11, hr: 1'b1, g: 2'b01, out: 1, own: 1};
        tbl[3] = '{v: 2'b11, hr: 1'b1, g: 2'b10, out: 1, own: 0};
        for (int i = 0; i < 4; i++) begin
            step(tbl[i].v, tbl[i].hr, g, o, ow, pd);
            chk("tbl_grant", g, tbl[i].g);
            chk("tbl_out", o, tbl[i].out);
            if (tbl[i].hr) chk("tbl_owner", ow, tbl[i].own);
        end

        // 3: credit refill race at full credit
        do_reset();
        for (int i = 0; i < QS; i++) step(2'b01, 1'b0, g, o, ow, pd);
        step(2'b10, 1'b1, g, o, ow, pd);
        chk("race_grant", g, 2'b10);
        chk("race_out_before", o, QS);
        step(2'b00, 1'b0, g, o, ow, pd);
        chk("race_out_after", o, QS);

        // 4: ownership order R0,R1,R1,R0
        do_reset();
        step(2'b01, 1'b0, g, o, ow, pd);
        step(2'b10, 1'b0, g, o, ow, pd);
        step(2'b10, 1'b0, g, o, ow, pd);
        step(2'b01, 1'b0, g, o, ow, pd);
        exp_own = '{0, 1, 1, 0};
        for (int i = 0; i < 4; i++) begin
            step(2'b00, 1'b1, g, o, ow, pd);
            chk("order_owner", ow, exp_own[i]);
        end

        // 5: reset mid-operation
        do_reset();
        for (int i = 0; i < 5; i++) step(2'b01, 1'b0, g, o, ow, pd);
        step(2'b00, 1'b0, g, o, ow, pd);
        chk("pre_rst_out", o, 5);
        do_reset();
        #1;
        chk("post_rst_out", outstanding, '0);
        chk("post_rst_issue", issue_valid, 1'b0);
        step(2'b11, 1'b0, g, o, ow, pd);
        chk("post_rst_rr", g, 2'b01);
        step(2'b00, 1'b0, g, o, ow, pd);
        step(2'b00, 1'b1, g, o, ow, pd);
        chk("post_rst_owner", ow, 0);

        // 6: hold rule under credit stall, rrPtr=1 favours R1
        do_reset();
        for (int i = 0; i < QS; i++) step(2'b01, 1'b0, g, o, ow, pd);
        step(2'b11, 1'b0, g, o, ow, pd);
        hold = req_data[1];
        for (int i = 0; i < 3; i++) begin
            step(2'b11, 1'b0, g, o, ow, pd);
            chk("stall_no_grant", g, '0);
        end
        step(2'b11, 1'b1, g, o, ow, pd);
        chk("hold_grant", g, 2'b10);
        chk("hold_data", pd, hold);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
